target_lut_encoder: RTL

Reverse-direction companion to the branch-target lookup table. It holds a writable table of 8-bit jump targets indexed by a 5-bit pointer. Given a target PC, it runs a sequential search and returns the pointer that produces that target. The assembler-verification harness and the control unit's branch-shortening path use it to map an absolute target back to a LUT index.

---
 rtl/target_lut_encoder_if.sv | 26 ++
 rtl/target_lut_encoder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/target_lut_encoder_if.sv
// Request/response bundle for target_lut_encoder: table writes, search requests and search results.
interface target_lut_encoder_if #(
    parameter int ADDR_W = 5,
    parameter int TGT_W  = 8
);
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [TGT_W-1:0]  WrData;
    logic              Start;
    logic [TGT_W-1:0]  Target;
    logic              Busy;
    logic              Done;
    logic              Hit;
    logic [ADDR_W-1:0] Addr;
    logic              MultiHit;

    modport master (
        output WrEn, WrAddr, WrData, Start, Target,
        input  Busy, Done, Hit, Addr, MultiHit
    );

    modport slave (
        input  WrEn, WrAddr, WrData, Start, Target,
        output Busy, Done, Hit, Addr, MultiHit
    );
endinterface

// File: rtl/target_lut_encoder.sv
// Reverse branch-target lookup: sequentially scans a writable target table for a PC and returns its index.
// Optional macro TARGET_LUT_ENC_MULTIHIT_EN: always scan every entry and flag multiple matches on MultiHit.
module target_lut_encoder #(
    parameter int ADDR_W = 5,
    parameter int TGT_W  = 8,
    parameter int DEPTH  = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    target_lut_encoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [TGT_W-1:0]  RST_DATA = TGT_W'(1);

    state_t            r_state;
    logic [TGT_W-1:0]  r_table [DEPTH];
    logic              r_valid [DEPTH];
    logic [TGT_W-1:0]  r_tgt;
    logic [ADDR_W-1:0] r_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_hit;
    logic [ADDR_W-1:0] r_addr;
    logic [DEPTH-1:0]  w_hit_vec;
    logic              w_match;

    // Per-entry compare gated by the scan pointer; avoids indexing the table with a wider pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign w_hit_vec[gi] = r_valid[gi] && (r_table[gi] == r_tgt) && (r_idx == ADDR_W'(gi));
        end
    endgenerate

    assign w_match = |w_hit_vec;

    // Addresses at or above DEPTH never equal any entry index, so such writes fall away.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= RST_DATA;
                r_valid[i] <= 1'b0;
            end
        end else if (bus.WrEn) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.WrAddr == ADDR_W'(i)) begin
                    r_table[i] <= bus.WrData;
                    r_valid[i] <= 1'b1;
                end
            end
        end
    end

`ifdef TARGET_LUT_ENC_MULTIHIT_EN
    logic              r_found;
    logic [ADDR_W-1:0] r_first_idx;
    logic              r_multi_acc;
    logic              r_multi;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_tgt   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hit   <= 1'b0;
            r_addr  <= '0;
`ifdef TARGET_LUT_ENC_MULTIHIT_EN
            r_found     <= 1'b0;
            r_first_idx <= '0;
            r_multi_acc <= 1'b0;
            r_multi     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.Start) begin
                        r_tgt   <= bus.Target;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_hit   <= 1'b0;
                        r_addr  <= '0;
                        r_state <= SEARCH;
`ifdef TARGET_LUT_ENC_MULTIHIT_EN
                        r_found     <= 1'b0;
                        r_first_idx <= '0;
                        r_multi_acc <= 1'b0;
                        r_multi     <= 1'b0;
`endif
                    end
                end
                SEARCH: begin
`ifdef TARGET_LUT_ENC_MULTIHIT_EN
                    if (w_match && !r_found) begin
                        r_found     <= 1'b1;
                        r_first_idx <= r_idx;
                    end
                    if (w_match && r_found) begin
                        r_multi_acc <= 1'b1;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_hit   <= r_found | w_match;
                        r_addr  <= r_found ? r_first_idx : (w_match ? r_idx : '0);
                        r_multi <= r_multi_acc | (r_found & w_match);
                    end else begin
                        r_idx <= r_idx + ADDR_W'(1);
                    end
`else
                    if (w_match) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_hit   <= 1'b1;
                        r_addr  <= r_idx;
                    end else if (r_idx == LAST_IDX) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_hit   <= 1'b0;
                        r_addr  <= '0;
                    end else begin
                        r_idx <= r_idx + ADDR_W'(1);
                    end
`endif
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Busy = r_busy;
    assign bus.Done = r_done;
    assign bus.Hit  = r_hit;
    assign bus.Addr = r_addr;
`ifdef TARGET_LUT_ENC_MULTIHIT_EN
    assign bus.MultiHit = r_multi;
`else
    assign bus.MultiHit = 1'b0;
`endif

endmodule
